pwl_conv_seq: RTL and testbench
===============================

Name: pwl_conv_seq

Overview:
- Sequencer and accumulator around one shared pwl step-response evaluator.
- Holds the last N_EDGES transition timestamps of a TX bit stream in a circular buffer.
- On each start request it walks every slot: drives t = t_now - edge_time into the pwl, takes v back one cycle later (synchronous ROM latency) and sums ±v.
- Produces one superposed channel output sample per request for the downstream RX model.

Parameters:
- N_EDGES, 8, number of edge slots (power of 2, >= 2).
- time_bits, 24, width of absolute timestamps.
- pwl_addr_bits, 14, width of t driven to pwl.
- pwl_data_bits, 16, width of signed v returned by pwl.
- acc_bits, 20, width of signed accumulator and output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- edge_valid  in  1  new transition offered.
- edge_ready  out  1  slot push accepted when edge_valid && edge_ready.
- edge_dir  in  1  1 = rising (+step), 0 = falling (-step).
- edge_time  in  time_bits  absolute timestamp of the transition.
- v_settled  in  pwl_data_bits  signed final value of the step response.
- start  in  1  evaluation request; sampled only in IDLE.
- t_now  in  time_bits  sample time, captured with start.
- busy  out  1  high from the cycle after start until out_valid inclusive.
- pwl_t  out  pwl_addr_bits  time offset to the pwl t input.
- pwl_v  in  pwl_data_bits  signed pwl v output, valid 1 cycle after pwl_t.
- out_valid  out  1  one-cycle pulse, sum ready.
- out_sum  out  acc_bits  signed result; holds until the next out_valid.

Behaviour:
- Reset: all slots invalid; baseline = 0; wr_ptr = 0; FSM = IDLE. Outputs: edge_ready = 1, busy = 0, out_valid = 0, out_sum = 0, pwl_t = 0.
- Edge push: edge_ready = 1 only in IDLE.
  - On accept, write {dir, time} at wr_ptr, set that slot valid, then wr_ptr++ (wraps modulo N_EDGES).
  - If the target slot is already valid (buffer full), evict it first: baseline += (dir_old ? +v_settled : -v_settled), sign-extended to acc_bits.
- Start: in IDLE, with start = 1 and no push in the same cycle, capture t_now, clear acc and go to ISSUE with k = 0.
  - If start and edge_valid are both high, the push is accepted and start is ignored; the requester must re-assert start.
- ISSUE (N_EDGES cycles, k = 0..N-1):
  - diff = t_now - time[k], computed as a time_bits+1 signed value.
  - pwl_t = all-ones if diff >= 2^pwl_addr_bits; otherwise diff[pwl_addr_bits-1:0].
  - Slot is masked (contributes 0) if invalid or diff < 0; pwl_t = 0 for a masked slot.
  - Register {masked, dir} into a 1-stage delay line aligned to pwl_v.
- Accumulate: in the cycle after each issue, acc += masked ? 0 : (dir ? pwl_v : -pwl_v), with pwl_v sign-extended.
- DRAIN (1 cycle): accumulate the last slot's return.
- DONE (1 cycle): out_sum = acc + baseline, out_valid = 1, then return to IDLE.
- Latency: start at cycle 0 → out_valid at cycle N_EDGES+2.
- Arithmetic: all sums are two's-complement and wrap at acc_bits; no saturation.
- Reset mid-run: the sequence is abandoned and all state returns to reset values; no out_valid is produced.

Optional Feature:
- Macro: PWL_CONV_RETIRE_EN.
- Defined: every valid, non-masked slot whose diff saturated during the run is retired in DONE.
  - Its ±v_settled is folded into baseline and the slot is cleared.
  - The new baseline takes effect from the next run; the current out_sum is unchanged by retirement.
  - Multiple retirements in the same cycle sum.
- Undefined: slots leave the buffer only by eviction on push.

Test Plan:
Bench pwl model: v = min(t, 100), 1-cycle latency. Settings: v_settled = 100, N_EDGES = 4, pwl_addr_bits = 8.
- Reset, then start with t_now = 50 → out_valid at cycle 6, out_sum = 0; edge_ready = 1.
- Push rise@10, start t_now = 40 → out_sum = 30; busy high for cycles 1..6.
- Push rise@10, fall@20, start t_now = 60 → 50 - 40 = 10. Start t_now = 15 → 5; the fall edge is masked (diff < 0).
- Push 5 alternating edges at 0, 10, 20, 30, 40 (rise first) → rise@0 is evicted, baseline = 100. Start t_now = 45 gives 100 - 35 + 25 - 15 + 5 = 80.
- Push rise@0, start t_now = 1000 → pwl_t = 255, out_sum = 100.
  - With PWL_CONV_RETIRE_EN: the slot is cleared and baseline = 100; a second start also gives 100.
- Assert rst_n low mid-ISSUE → busy = 0 immediately, no out_valid; a following start with no edges gives 0.

Source files
------------

// File: rtl/pwl_conv_seq_if.sv
// Bundle between pwl_conv_seq and its surroundings: edge push, evaluation request,
// pwl evaluator lookup and result. The slave modport is the sequencer side.
interface pwl_conv_seq_if #(
  parameter int unsigned TIME_BITS     = 24,
  parameter int unsigned PWL_ADDR_BITS = 14,
  parameter int unsigned PWL_DATA_BITS = 16,
  parameter int unsigned ACC_BITS      = 20
);
  logic                     edge_valid;
  logic                     edge_ready;
  logic                     edge_dir;
  logic [TIME_BITS-1:0]     edge_time;
  logic [PWL_DATA_BITS-1:0] v_settled;
  logic                     start;
  logic [TIME_BITS-1:0]     t_now;
  logic                     busy;
  logic [PWL_ADDR_BITS-1:0] pwl_t;
  logic [PWL_DATA_BITS-1:0] pwl_v;
  logic                     out_valid;
  logic [ACC_BITS-1:0]      out_sum;

  modport master (
    output edge_valid, edge_dir, edge_time, v_settled, start, t_now, pwl_v,
    input  edge_ready, busy, pwl_t, out_valid, out_sum
  );

  modport slave (
    input  edge_valid, edge_dir, edge_time, v_settled, start, t_now, pwl_v,
    output edge_ready, busy, pwl_t, out_valid, out_sum
  );
endinterface

// File: rtl/pwl_conv_seq.sv
// Superposes the pwl step responses of the last N_EDGES TX transitions into one channel sample.
// Optional PWL_CONV_RETIRE_EN: slots whose offset saturated are folded into the baseline in DONE.
module pwl_conv_seq #(
  parameter int unsigned N_EDGES       = 8,
  parameter int unsigned TIME_BITS     = 24,
  parameter int unsigned PWL_ADDR_BITS = 14,
  parameter int unsigned PWL_DATA_BITS = 16,
  parameter int unsigned ACC_BITS      = 20
) (
  input logic           clk,
  input logic           rst_n,
  pwl_conv_seq_if.slave bus
);

  localparam int unsigned K_BITS    = $clog2(N_EDGES);
  localparam int unsigned DIFF_BITS = TIME_BITS + 1;
  localparam logic [K_BITS-1:0] K_LAST = K_BITS'(N_EDGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                 dir;
    logic [TIME_BITS-1:0] t;
  } slot_t;

  // Per-lookup tag travelling alongside pwl_t and then pwl_v.
  typedef struct packed {
    logic vld;
    logic masked;
    logic dir;
  } tag_t;

  state_t                     state_q, state_nxt;
  slot_t                      slot_q [N_EDGES];
  logic [N_EDGES-1:0]         valid_q, valid_nxt;
  logic [K_BITS-1:0]          wr_ptr_q, k_q, k_nxt;
  logic [TIME_BITS-1:0]       tnow_q, tnow_nxt;
  logic signed [ACC_BITS-1:0] acc_q, acc_nxt;
  logic signed [ACC_BITS-1:0] base_q, base_nxt;
  logic signed [ACC_BITS-1:0] out_sum_nxt, v_ext, vs_ext;
  tag_t                       iss_q, iss_nxt, acc_tag_q;
  logic [PWL_ADDR_BITS-1:0]   pwl_t_nxt;
  logic                       push, go;
  slot_t                      sel;
  logic [DIFF_BITS-1:0]       diff;
  logic                       diff_neg, diff_sat, slot_masked;
`ifdef PWL_CONV_RETIRE_EN
  logic [N_EDGES-1:0]         sat_q, sat_nxt;
`endif

  // Control: handshake decode and sequencing.
  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    tnow_nxt  = tnow_q;
    push      = (state_q == S_IDLE) && bus.edge_valid;
    go        = (state_q == S_IDLE) && bus.start && !bus.edge_valid;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_ISSUE;
          k_nxt     = '0;
          tnow_nxt  = bus.t_now;
        end
      end
      S_ISSUE: begin
        k_nxt = k_q + K_BITS'(1);
        if (k_q == K_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Issue path: look up the slot for the coming cycle so pwl_t can leave a register.
  always_comb begin
    sel            = slot_q[k_nxt];
    diff           = {1'b0, tnow_nxt} - {1'b0, sel.t};
    diff_neg       = diff[TIME_BITS];
    diff_sat       = !diff_neg && (|diff[TIME_BITS-1:PWL_ADDR_BITS]);
    slot_masked    = !valid_q[k_nxt] || diff_neg;
    iss_nxt.vld    = (state_nxt == S_ISSUE);
    iss_nxt.masked = slot_masked;
    iss_nxt.dir    = sel.dir;
    pwl_t_nxt      = '0;
    if (iss_nxt.vld && !slot_masked) begin
      pwl_t_nxt = diff_sat ? '1 : diff[PWL_ADDR_BITS-1:0];
    end
  end

  // Accumulate the signed pwl return one cycle behind its issue.
  always_comb begin
    v_ext   = ACC_BITS'($signed(bus.pwl_v));
    acc_nxt = acc_q;
    if (go) begin
      acc_nxt = '0;
    end else if (acc_tag_q.vld && !acc_tag_q.masked) begin
      acc_nxt = acc_tag_q.dir ? acc_q + v_ext : acc_q - v_ext;
    end
    out_sum_nxt = acc_nxt + base_q;
  end

  // Baseline absorbs settled steps of edges leaving the buffer.
  always_comb begin
    vs_ext    = ACC_BITS'($signed(bus.v_settled));
    base_nxt  = base_q;
    valid_nxt = valid_q;
`ifdef PWL_CONV_RETIRE_EN
    sat_nxt = sat_q;
    if (iss_nxt.vld) sat_nxt[k_nxt] = !slot_masked && diff_sat;
`endif
    if (push) begin
      if (valid_q[wr_ptr_q]) begin
        base_nxt = slot_q[wr_ptr_q].dir ? base_q + vs_ext : base_q - vs_ext;
      end
      valid_nxt[wr_ptr_q] = 1'b1;
    end
`ifdef PWL_CONV_RETIRE_EN
    if (state_q == S_DONE) begin
      for (int unsigned i = 0; i < N_EDGES; i++) begin
        if (sat_q[K_BITS'(i)] && valid_q[K_BITS'(i)]) begin
          base_nxt = slot_q[K_BITS'(i)].dir ? base_nxt + vs_ext : base_nxt - vs_ext;
          valid_nxt[K_BITS'(i)] = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Slot payload needs no reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_q[wr_ptr_q].dir <= bus.edge_dir;
      slot_q[wr_ptr_q].t   <= bus.edge_time;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      wr_ptr_q       <= '0;
      base_q         <= '0;
      k_q            <= '0;
      tnow_q         <= '0;
      acc_q          <= '0;
      iss_q          <= '0;
      acc_tag_q      <= '0;
`ifdef PWL_CONV_RETIRE_EN
      sat_q          <= '0;
`endif
      bus.edge_ready <= 1'b1;
      bus.busy       <= 1'b0;
      bus.pwl_t      <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sum    <= '0;
    end else begin
      valid_q        <= valid_nxt;
      base_q         <= base_nxt;
      k_q            <= k_nxt;
      tnow_q         <= tnow_nxt;
      acc_q          <= acc_nxt;
      iss_q          <= iss_nxt;
      acc_tag_q      <= iss_q;
`ifdef PWL_CONV_RETIRE_EN
      sat_q          <= sat_nxt;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + K_BITS'(1);
      bus.edge_ready <= (state_nxt == S_IDLE);
      bus.busy       <= (state_nxt != S_IDLE);
      bus.pwl_t      <= pwl_t_nxt;
      bus.out_valid  <= (state_nxt == S_DONE);
      if (state_q == S_DRAIN) bus.out_sum <= out_sum_nxt;
    end
  end

endmodule

// File: tb/tb_pwl_conv_seq.sv
// Bench for pwl_conv_seq: pwl model v = min(t,100), v_settled = 100, N_EDGES = 4, 8-bit pwl_t.
// Directed cases plus random edge streams checked against a queue-based superposition model.
module tb_pwl_conv_seq;
  localparam int unsigned N  = 4;
  localparam int unsigned TB = 24;
  localparam int unsigned AB = 8;
  localparam int unsigned DB = 16;
  localparam int unsigned CB = 20;
  localparam int          VS = 100;
  localparam int          T_MAX = (1 << AB) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pwl_conv_seq_if #(.TIME_BITS(TB), .PWL_ADDR_BITS(AB), .PWL_DATA_BITS(DB), .ACC_BITS(CB)) bus ();

  pwl_conv_seq #(
    .N_EDGES(N), .TIME_BITS(TB), .PWL_ADDR_BITS(AB), .PWL_DATA_BITS(DB), .ACC_BITS(CB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Step-response ROM with one cycle of latency.
  always_ff @(posedge clk) bus.pwl_v <= (bus.pwl_t < AB'(100)) ? DB'(bus.pwl_t) : DB'(100);

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: the last N pushes, each possibly retired; baseline of departed steps.
  typedef struct {
    bit dir;
    int t;
    bit ret;
  } ev_t;
  ev_t evq[$];
  int  base_m;

  function automatic void m_reset();
    evq.delete();
    base_m = 0;
  endfunction

  function automatic void m_push(input bit d, input int t);
    ev_t e;
    if (evq.size() == N) begin
      e = evq.pop_front();
      if (!e.ret) base_m += e.dir ? VS : -VS;
    end
    e.dir = d; e.t = t; e.ret = 1'b0;
    evq.push_back(e);
  endfunction

  function automatic int m_eval(input int tn);
    int s, d, pt, v;
    s = base_m;
    foreach (evq[i]) begin
      if (!evq[i].ret) begin
        d = tn - evq[i].t;
        if (d >= 0) begin
          pt = (d > T_MAX) ? T_MAX : d;
          v  = (pt < 100) ? pt : 100;
          s += evq[i].dir ? v : -v;
`ifdef PWL_CONV_RETIRE_EN
          if (d > T_MAX) begin
            base_m += evq[i].dir ? VS : -VS;
            evq[i].ret = 1'b1;
          end
`endif
        end
      end
    end
    return s;
  endfunction

  function automatic int wrap_acc(input int x);
    logic signed [CB-1:0] w;
    w = CB'(x);
    return int'(w);
  endfunction

  task automatic do_reset();
    bus.edge_valid = 1'b0;
    bus.start      = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  task automatic push(input bit d, input int t);
    chk("edge_ready", bus.edge_ready, 1);
    bus.edge_valid = 1'b1;
    bus.edge_dir   = d;
    bus.edge_time  = TB'(t);
    @(posedge clk);
    #1 bus.edge_valid = 1'b0;
    m_push(d, t);
  endtask

  // One evaluation; pt_exp < 0 skips the peak-pwl_t check.
  task automatic run(input string tag, input int tn, input int pt_exp);
    int exp, bm, ovm, sum, ptmax;
    exp = wrap_acc(m_eval(tn));
    bus.start = 1'b1;
    bus.t_now = TB'(tn);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bm = 0; ovm = 0; sum = 0; ptmax = 0;
    for (int c = 1; c <= int'(N) + 5; c++) begin
      @(negedge clk);
      if (bus.busy) bm |= (1 << c);
      if (bus.out_valid) begin
        ovm |= (1 << c);
        sum = int'($signed(bus.out_sum));
      end
      if (int'(bus.pwl_t) > ptmax) ptmax = int'(bus.pwl_t);
    end
    @(posedge clk);
    #1;
    chk({tag, ".busy_cycles"}, bm, ((1 << (N + 3)) - 1) & ~1);
    chk({tag, ".valid_cycle"}, ovm, 1 << (N + 2));
    chk({tag, ".out_sum"}, sum, exp);
    chk({tag, ".out_sum_hold"}, int'($signed(bus.out_sum)), exp);
    if (pt_exp >= 0) chk({tag, ".pwl_t_peak"}, ptmax, pt_exp);
  endtask

  initial begin
    int tcur, tn, np, ov;
    bus.edge_valid = 1'b0;
    bus.edge_dir   = 1'b0;
    bus.edge_time  = '0;
    bus.v_settled  = DB'(VS);
    bus.start      = 1'b0;
    bus.t_now      = '0;
    m_reset();

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.edge_ready", bus.edge_ready, 1);
    chk("rst.busy", bus.busy, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_sum", bus.out_sum, 0);
    chk("rst.pwl_t", bus.pwl_t, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("empty", 50, 0);

    do_reset();
    push(1'b1, 10);
    run("one_rise", 40, 30);

    do_reset();
    push(1'b1, 10);
    push(1'b0, 20);
    run("rise_fall", 60, -1);
    run("fall_masked", 15, 5);

    do_reset();
    for (int i = 0; i < 5; i++) push(i[0] == 1'b0, 10 * i);
    run("evict", 45, -1);

    do_reset();
    push(1'b1, 0);
    run("sat", 1000, T_MAX);
    run("sat_again", 1000, -1);

    // Push and start together: the push wins, start is dropped.
    do_reset();
    bus.edge_valid = 1'b1;
    bus.edge_dir   = 1'b1;
    bus.edge_time  = TB'(5);
    bus.start      = 1'b1;
    bus.t_now      = TB'(30);
    @(posedge clk);
    #1;
    bus.edge_valid = 1'b0;
    bus.start      = 1'b0;
    m_push(1'b1, 5);
    @(negedge clk);
    chk("collide.busy", bus.busy, 0);
    @(posedge clk);
    #1;
    run("collide", 30, -1);

    // Reset while issuing abandons the run.
    do_reset();
    push(1'b1, 10);
    bus.start = 1'b1;
    bus.t_now = TB'(50);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", bus.busy, 0);
    chk("midrst.edge_ready", bus.edge_ready, 1);
    ov = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (bus.out_valid) ov = 1;
    end
    chk("midrst.no_valid", ov, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    run("after_rst", 50, 0);

    // Random edge streams, offsets spanning masked, linear, settled and saturated.
    do_reset();
    tcur = 0;
    for (int it = 0; it < 30; it++) begin
      np = int'($urandom_range(0, 5));
      for (int j = 0; j < np; j++) begin
        tcur += int'($urandom_range(1, 120));
        push(1'($urandom_range(0, 1)), tcur);
      end
      tn = tcur + int'($urandom_range(0, 500)) - 150;
      if (tn < 0) tn = 0;
      run("rnd", tn, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
